// File: rtl/cnn_frame_feeder.sv
// rtl/cnn_frame_feeder.sv - host-side frame/weight feeder for the CNN top.
// Optional FEEDER_CHECKSUM_EN adds px_checksum, the modulo sum of transferred pixels.
module cnn_frame_feeder #(
  parameter int BitSize       = 32,
  parameter int ImageWidth    = 8,
  parameter int M_W_BitSize   = 8,
  parameter int MaxNumNerves  = 8,
  parameter int NumLayers     = 4,
  parameter int WordsPerLayer = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                                         clk,
  input  logic                                         res_n,
  input  logic                                         host_px_we,
  input  logic [$clog2(ImageWidth*ImageWidth)-1:0]     host_px_addr,
  input  logic [BitSize-1:0]                           host_px_data,
  input  logic                                         host_w_we,
  input  logic [$clog2(NumLayers*WordsPerLayer)-1:0]   host_w_addr,
  input  logic [MaxNumNerves*M_W_BitSize-1:0]          host_w_data,
  input  logic                                         start,
  input  logic                                         cfg_load_w,
  input  logic                                         cnn_ready,
  input  logic                                         cnn_done,
  output logic                                         out_valid,
  output logic [BitSize-1:0]                           out_data,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0]     out_weights,
  output logic [NumLayers-1:0]                         out_load_weights,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err_timeout
`ifdef FEEDER_CHECKSUM_EN
  , output logic [BitSize-1:0]                         px_checksum
`endif
);

  localparam int NumPixels = ImageWidth * ImageWidth;
  localparam int NumWords  = NumLayers * WordsPerLayer;
  localparam int PA  = $clog2(NumPixels);
  localparam int WA  = $clog2(NumWords);
  localparam int LA  = $clog2(NumLayers);
  localparam int WDA = $clog2(WordsPerLayer);
  localparam int TA  = $clog2(TimeoutCycles);
  localparam int WW  = MaxNumNerves * M_W_BitSize;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, WAIT_DONE} state_t;

  state_t               state_q;
  logic [BitSize-1:0]   pbuf [NumPixels];
  logic [WW-1:0]        wbuf [NumWords];
  logic [PA-1:0]        idx_q;
  logic [LA-1:0]        layer_q, layer_d;
  logic [WDA-1:0]       word_q, word_d;
  logic [TA-1:0]        timer_q;
  logic                 valid_q, busy_q, done_q, err_q;
  logic [BitSize-1:0]   data_q, px_next, px_first;
  logic [WW-1:0]        weights_q, w_next, w_first;
  logic [NumLayers-1:0] load_q;
`ifdef FEEDER_CHECKSUM_EN
  logic [BitSize-1:0]   csum_q;
  assign px_checksum = csum_q;
`endif

  assign out_valid        = valid_q;
  assign out_data         = data_q;
  assign out_weights      = weights_q;
  assign out_load_weights = load_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err_timeout      = err_q;

  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (host_px_we) pbuf[host_px_addr] <= host_px_data;
      if (host_w_we)  wbuf[host_w_addr]  <= host_w_data;
    end
  end

  // A host write landing on the start edge is forwarded so word/pixel 0 is never stale.
  always_comb begin
    layer_d = layer_q;
    word_d  = word_q + 1'b1;
    if (word_q == WDA'(WordsPerLayer - 1)) begin
      word_d  = '0;
      layer_d = layer_q + 1'b1;
    end
    w_next   = wbuf[WA'(int'(layer_d) * WordsPerLayer + int'(word_d))];
    px_next  = pbuf[idx_q + PA'(1)];
    px_first = (host_px_we && host_px_addr == '0) ? host_px_data : pbuf[0];
    w_first  = (host_w_we && host_w_addr == '0) ? host_w_data : wbuf[0];
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      layer_q   <= '0;
      word_q    <= '0;
      timer_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      weights_q <= '0;
      load_q    <= '0;
`ifdef FEEDER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy_q <= 1'b1;
          err_q  <= 1'b0;
`ifdef FEEDER_CHECKSUM_EN
          csum_q <= '0;
`endif
          if (cfg_load_w) begin
            state_q   <= LOAD_W;
            layer_q   <= '0;
            word_q    <= '0;
            weights_q <= w_first;
            load_q    <= NumLayers'(1);
          end else begin
            state_q <= STREAM;
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= px_first;
          end
        end
        LOAD_W: begin
          if (layer_q == LA'(NumLayers - 1) && word_q == WDA'(WordsPerLayer - 1)) begin
            load_q  <= '0;
            state_q <= STREAM;
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= pbuf[0];
          end else begin
            layer_q   <= layer_d;
            word_q    <= word_d;
            weights_q <= w_next;
            load_q    <= NumLayers'(1) << layer_d;
          end
        end
        STREAM: if (cnn_ready) begin
`ifdef FEEDER_CHECKSUM_EN
          csum_q <= csum_q + data_q;
`endif
          if (idx_q == PA'(NumPixels - 1)) begin
            valid_q <= 1'b0;
            state_q <= WAIT_DONE;
            timer_q <= '0;
          end else begin
            idx_q  <= idx_q + 1'b1;
            data_q <= px_next;
          end
        end
        WAIT_DONE: begin
          if (cnn_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (timer_q == TA'(TimeoutCycles - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// tb/tb_cnn_frame_feeder.sv - randomized bench for cnn_frame_feeder against a frame-level model.
module tb_cnn_frame_feeder;
  localparam int NP  = 64;
  localparam int NL  = 4;
  localparam int WPL = 8;
  localparam int NW  = NL * WPL;
  localparam int TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 res_n, host_px_we, host_w_we, start, cfg_load_w, cnn_ready, cnn_done;
  logic [5:0]           host_px_addr;
  logic [4:0]           host_w_addr;
  logic [31:0]          host_px_data;
  logic [63:0]          host_w_data;
  logic                 out_valid, busy, done, err_timeout;
  logic [31:0]          out_data;
  logic [7:0][7:0]      out_weights;
  logic [NL-1:0]        out_load_weights;
`ifdef FEEDER_CHECKSUM_EN
  logic [31:0]          px_checksum;
`endif

  logic [31:0] pm [NP];
  logic [63:0] wm [NW];
  int vec_cnt = 0;
  int err_cnt = 0;

  cnn_frame_feeder #(.TimeoutCycles(TO)) dut (
    .clk(clk), .res_n(res_n),
    .host_px_we(host_px_we), .host_px_addr(host_px_addr), .host_px_data(host_px_data),
    .host_w_we(host_w_we), .host_w_addr(host_w_addr), .host_w_data(host_w_data),
    .start(start), .cfg_load_w(cfg_load_w), .cnn_ready(cnn_ready), .cnn_done(cnn_done),
    .out_valid(out_valid), .out_data(out_data), .out_weights(out_weights),
    .out_load_weights(out_load_weights), .busy(busy), .done(done), .err_timeout(err_timeout)
`ifdef FEEDER_CHECKSUM_EN
    , .px_checksum(px_checksum)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    host_px_we = 1'b0; host_w_we = 1'b0; start = 1'b0; cfg_load_w = 1'b0;
    cnn_ready = 1'b0; cnn_done = 1'b0;
    host_px_addr = '0; host_w_addr = '0; host_px_data = '0; host_w_data = '0;
  endtask

  task automatic busy_noise();
    host_px_we = 1'($urandom_range(0, 1)); host_px_addr = 6'($urandom); host_px_data = $urandom;
    host_w_we = 1'($urandom_range(0, 1)); host_w_addr = 5'($urandom); host_w_data = {$urandom, $urandom};
    start = 1'($urandom_range(0, 1)); cfg_load_w = 1'($urandom_range(0, 1));
  endtask

  // mode 0: pm[i]=i+100, 1: random, 2: all ones
  task automatic fill_px(input int mode);
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      pm[i] = (mode == 0) ? 32'(i + 100) : (mode == 1) ? $urandom : 32'd1;
      host_px_we = 1'b1; host_px_addr = 6'(i); host_px_data = pm[i];
      @(negedge clk);
    end
    host_px_we = 1'b0;
  endtask

  task automatic fill_w(input int mode);
    @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      wm[i] = (mode == 0) ? 64'(i) : {$urandom, $urandom};
      host_w_we = 1'b1; host_w_addr = 5'(i); host_w_data = wm[i];
      @(negedge clk);
    end
    host_w_we = 1'b0;
  endtask

  // rmode 0: ready always, 1: 1,0,0,1 pattern, 2: random. done_dly<0 means never signal done.
  task automatic run_frame(input bit load_w, input int rmode, input int done_dly,
                           input bit collide, input int reset_at);
    int n = 0;
    int cyc = 0;
    logic [31:0] sum = '0;
    @(negedge clk);
    start = 1'b1; cfg_load_w = load_w; cnn_ready = 1'b0; cnn_done = 1'b0;
    if (collide) begin
      pm[0] = $urandom;
      host_px_we = 1'b1; host_px_addr = '0; host_px_data = pm[0];
      if (load_w) begin
        wm[0] = {$urandom, $urandom};
        host_w_we = 1'b1; host_w_addr = '0; host_w_data = wm[0];
      end
    end
    @(negedge clk);
    idle_inputs();
    check_eq("busy_after_start", busy, 1);
    check_eq("err_cleared", err_timeout, 0);
    if (load_w) begin
      for (int k = 0; k < NW; k++) begin
        check_eq("w_strobe", out_load_weights, 64'(1) << (k / WPL));
        check_eq("w_word", out_weights, wm[k]);
        check_eq("w_valid_low", out_valid, 0);
        busy_noise();
        cnn_done = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    check_eq("strobe_off", out_load_weights, 0);
    while (n < NP && cyc < 2000) begin
      check_eq("px_valid", out_valid, 1);
      check_eq("px_data", out_data, pm[n]);
      if (reset_at >= 0 && n == reset_at) begin
        idle_inputs();
        res_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
`ifdef FEEDER_CHECKSUM_EN
        check_eq("rst_csum", px_checksum, 0);
`endif
        @(negedge clk);
        res_n = 1'b1;
        return;
      end
      busy_noise();
      cnn_done = 1'($urandom_range(0, 1));
      cnn_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                : 1'($urandom_range(0, 1));
      if (cnn_ready) begin
        sum += pm[n];
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    if (n < NP) check_eq("stream_bound", 0, 1);
    idle_inputs();
    cnn_ready = 1'($urandom_range(0, 1));
    for (int c = 0; c <= TO + 2; c++) begin
      check_eq("wait_valid", out_valid, 0);
      if (done_dly < 0) begin
        check_eq("to_done", done, 0);
        if (c < TO) begin
          check_eq("to_busy", busy, 1);
          check_eq("to_err_early", err_timeout, 0);
        end else begin
          check_eq("to_busy_end", busy, 0);
          check_eq("to_err", err_timeout, 1);
          break;
        end
      end else begin
        if (c <= done_dly) begin
          check_eq("done_early", done, 0);
          check_eq("wait_busy", busy, 1);
          cnn_done = (c == done_dly);
        end else if (c == done_dly + 1) begin
          cnn_done = 1'b0;
          check_eq("done_pulse", done, 1);
          check_eq("busy_fall", busy, 0);
          check_eq("no_err", err_timeout, 0);
`ifdef FEEDER_CHECKSUM_EN
          check_eq("csum", px_checksum, sum);
`endif
        end else begin
          check_eq("done_once", done, 0);
`ifdef FEEDER_CHECKSUM_EN
          check_eq("csum_hold", px_checksum, sum);
`endif
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy0", busy, 0);
    check_eq("rst_valid0", out_valid, 0);
    check_eq("rst_done0", done, 0);
    check_eq("rst_err0", err_timeout, 0);
    check_eq("rst_load0", out_load_weights, 0);
    check_eq("rst_data0", out_data, 0);
    check_eq("rst_w0", out_weights, 0);
    res_n = 1'b1;
    fill_w(0);
    fill_px(0);
    run_frame(1, 0, 5, 0, -1);
    run_frame(0, 1, 5, 0, -1);
    run_frame(0, 0, -1, 0, -1);
    run_frame(0, 2, 3, 1, -1);
    fill_px(1);
    fill_w(1);
    run_frame(1, 2, 0, 1, -1);
    run_frame(0, 0, 5, 0, 20);
    run_frame(0, 0, 5, 0, -1);
    fill_px(2);
    run_frame(0, 0, 5, 0, -1);
    for (int r = 0; r < 3; r++) begin
      fill_px(1);
      run_frame(1'($urandom_range(0, 1)), 2, $urandom_range(0, 10), 1'($urandom_range(0, 1)), -1);
    end
    run_frame(1, 1, -1, 0, -1);
    run_frame(0, 2, 2, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
